// File: rtl/unit_l_sequencer.sv
// rtl/unit_l_sequencer.sv - drives unit_L through AND/OR/XOR and returns the three results
module unit_l_sequencer #(
  parameter int WIDTH    = 32,
  parameter bit CHECK_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] l_a,
  output logic [WIDTH-1:0] l_b,
  output logic [1:0]       l_S,
  input  logic [WIDTH-1:0] l_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_and,
  output logic [WIDTH-1:0] res_or,
  output logic [WIDTH-1:0] res_xor,
  output logic             mismatch
);

  localparam logic [1:0] OP_IDLE = 2'b00;
  localparam logic [1:0] OP_AND  = 2'b01;
  localparam logic [1:0] OP_OR   = 2'b10;
  localparam logic [1:0] OP_XOR  = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S_AND = 3'd1,
    S_OR  = 3'd2,
    S_XOR = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state;
  state_t state_next;

  logic             accept;
  logic             release_res;
  logic [WIDTH-1:0] expected;
  logic             in_op;
  logic             check_hit;

  assign accept      = in_valid && in_ready;
  assign release_res = res_valid && res_ready;

  // State register; reset aborts any sequence in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic plus the state-decoded handshake and opcode outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    res_valid  = 1'b0;
    l_S        = OP_IDLE;
    in_op      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = S_AND;
        end
      end
      S_AND: begin
        l_S        = OP_AND;
        in_op      = 1'b1;
        state_next = S_OR;
      end
      S_OR: begin
        l_S        = OP_OR;
        in_op      = 1'b1;
        state_next = S_XOR;
      end
      S_XOR: begin
        l_S        = OP_XOR;
        in_op      = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Reference result for the operation currently presented to unit_L.
  always_comb begin
    expected = '0;
    case (l_S)
      OP_AND:  expected = l_a & l_b;
      OP_OR:   expected = l_a | l_b;
      OP_XOR:  expected = l_a ^ l_b;
      default: expected = '0;
    endcase
  end

  assign check_hit = CHECK_EN && in_op && (l_out != expected);

  // Operand latches: loaded only on accept so mid-sequence input changes are invisible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l_a <= '0;
      l_b <= '0;
    end else if (accept) begin
      l_a <= a_in;
      l_b <= b_in;
    end
  end

  // Result capture: cleared on accept, one field filled per operation state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_and <= '0;
      res_or  <= '0;
      res_xor <= '0;
    end else if (accept) begin
      res_and <= '0;
      res_or  <= '0;
      res_xor <= '0;
    end else begin
      case (state)
        S_AND:   res_and <= l_out;
        S_OR:    res_or  <= l_out;
        S_XOR:   res_xor <= l_out;
        default: ;
      endcase
    end
  end

  // Sticky mismatch flag, held through DONE and cleared by the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mismatch <= 1'b0;
    end else if (accept) begin
      mismatch <= 1'b0;
    end else if (check_hit) begin
      mismatch <= 1'b1;
    end
  end

  logic unused_release;
  assign unused_release = release_res;

endmodule

// File: tb/tb_unit_l_sequencer.sv
// tb/tb_unit_l_sequencer.sv - directed self-checking bench for unit_l_sequencer
module tb_unit_l_sequencer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [31:0] l_a;
  logic [31:0] l_b;
  logic [1:0]  l_S;
  logic [31:0] l_out;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_and;
  logic [31:0] res_or;
  logic [31:0] res_xor;
  logic        mismatch;
  logic        fault;

  int tests;
  int fails;

  unit_l_sequencer #(.WIDTH(32), .CHECK_EN(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .l_a       (l_a),
    .l_b       (l_b),
    .l_S       (l_S),
    .l_out     (l_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_and   (res_and),
    .res_or    (res_or),
    .res_xor   (res_xor),
    .mismatch  (mismatch)
  );

  // unit_L model; fault forces the XOR result to zero
  always_comb begin
    case (l_S)
      2'b01:   l_out = l_a & l_b;
      2'b10:   l_out = l_a | l_b;
      2'b11:   l_out = fault ? 32'h0 : (l_a ^ l_b);
      default: l_out = 32'h0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_results(input string tag, input logic [31:0] ea, input logic [31:0] eo,
                               input logic [31:0] ex, input logic em);
    chk({tag, " res_valid"}, {31'b0, res_valid}, 32'd1);
    chk({tag, " res_and"}, res_and, ea);
    chk({tag, " res_or"}, res_or, eo);
    chk({tag, " res_xor"}, res_xor, ex);
    chk({tag, " mismatch"}, {31'b0, mismatch}, {31'b0, em});
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a_in      = 32'h0;
    b_in      = 32'h0;
    res_ready = 1'b0;
    fault     = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();

    // T1: asynchronous reset while idle
    #2 rst = 1'b1;
    #1;
    chk("t1 in_ready", {31'b0, in_ready}, 32'd1);
    chk("t1 l_S", {30'b0, l_S}, 32'd0);
    chk("t1 res_valid", {31'b0, res_valid}, 32'd0);
    chk("t1 l_a", l_a, 32'h0);
    chk("t1 res_and", res_and, 32'h0);
    chk("t1 mismatch", {31'b0, mismatch}, 32'd0);
    step();
    rst = 1'b0;
    step();

    // T2 + T4: basic sequence with an ignored pair offered during S_OR
    res_ready = 1'b1;
    in_valid  = 1'b1;
    a_in      = 32'hDC754CD2;
    b_in      = 32'h4124F055;
    step();
    in_valid = 1'b0;
    a_in     = 32'h0;
    chk("t2 l_S and", {30'b0, l_S}, 32'd1);
    chk("t2 in_ready busy", {31'b0, in_ready}, 32'd0);
    chk("t2 l_a held", l_a, 32'hDC754CD2);
    step();
    chk("t2 l_S or", {30'b0, l_S}, 32'd2);
    in_valid = 1'b1;
    a_in     = 32'hFFFFFFFF;
    b_in     = 32'h00000000;
    step();
    chk("t2 l_S xor", {30'b0, l_S}, 32'd3);
    chk("t4 l_b unchanged", l_b, 32'h4124F055);
    step();
    chk("t2 l_S done", {30'b0, l_S}, 32'd0);
    check_results("t2", 32'h40244050, 32'hDD75FCD7, 32'h9D51BC87, 1'b0);
    step();
    chk("t2 back idle", {31'b0, in_ready}, 32'd1);
    chk("t2 res_valid low", {31'b0, res_valid}, 32'd0);
    step();
    in_valid = 1'b0;
    chk("t4 accepted", {30'b0, l_S}, 32'd1);
    chk("t4 l_a", l_a, 32'hFFFFFFFF);
    step();
    step();
    step();
    check_results("t4", 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    step();

    // T3: backpressure holds DONE
    res_ready = 1'b0;
    in_valid  = 1'b1;
    a_in      = 32'hDC754CD2;
    b_in      = 32'h4124F055;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    for (int i = 0; i < 6; i++) begin
      check_results("t3 hold", 32'h40244050, 32'hDD75FCD7, 32'h9D51BC87, 1'b0);
      chk("t3 in_ready", {31'b0, in_ready}, 32'd0);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
    end
    res_ready = 1'b1;
    step();
    chk("t3 idle", {31'b0, in_ready}, 32'd1);
    chk("t3 res_valid low", {31'b0, res_valid}, 32'd0);

    // T5: fault on XOR result
    fault    = 1'b1;
    in_valid = 1'b1;
    a_in     = 32'hFFFF0000;
    b_in     = 32'h0F0F0F0F;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    check_results("t5", 32'h0F0F0000, 32'hFFFF0F0F, 32'h00000000, 1'b1);
    fault = 1'b0;
    step();
    in_valid = 1'b1;
    a_in     = 32'hDC754CD2;
    b_in     = 32'h4124F055;
    step();
    in_valid = 1'b0;
    chk("t5 mismatch cleared", {31'b0, mismatch}, 32'd0);
    step();
    step();
    step();
    check_results("t5 clean", 32'h40244050, 32'hDD75FCD7, 32'h9D51BC87, 1'b0);
    step();

    // T6: reset in S_OR aborts
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("t6 in S_OR", {30'b0, l_S}, 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("t6 l_S", {30'b0, l_S}, 32'd0);
    chk("t6 in_ready", {31'b0, in_ready}, 32'd1);
    chk("t6 res_and", res_and, 32'h0);
    chk("t6 l_a", l_a, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t6 no res_valid", {31'b0, res_valid}, 32'd0);
    end
    rst = 1'b0;
    step();
    chk("t6 idle after", {31'b0, res_valid}, 32'd0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    check_results("t6 rerun", 32'h40244050, 32'hDD75FCD7, 32'h9D51BC87, 1'b0);
    step();
    chk("t6 final idle", {31'b0, in_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
